// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if
//   Timing bundle published by the VGA sync generator to downstream object
//   generators (logos, sprites, text).
//   master : driven by vga_sync_gen
//   slave  : consumers of the timing
//   Signals:
//     hsync, vsync : registered sync outputs (polarity set by the generator)
//     video_on     : (pix_x, pix_y) lies inside the active area
//     p_tick       : pixel enable, one clk wide
//     refr_tick    : once-per-frame tick at the first line of vertical blanking
//     pix_x, pix_y : current pixel coordinates
interface vga_sync_gen_if;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       p_tick;
  logic       refr_tick;
  logic [9:0] pix_x;
  logic [9:0] pix_y;

  modport master (
    output hsync, vsync, video_on, p_tick, refr_tick, pix_x, pix_y
  );

  modport slave (
    input hsync, vsync, video_on, p_tick, refr_tick, pix_x, pix_y
  );
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen
//   Free-running VGA timing generator (640x480@60 by default). Divides clk
//   down to a pixel enable, keeps horizontal/vertical pixel counters and
//   drives registered hsync/vsync aligned with the counters.
//   Ports:
//     clk   : system clock
//     reset : asynchronous, active-high
//     vga   : timing bundle (master side): hsync, vsync, video_on, p_tick,
//             refr_tick, pix_x, pix_y
module vga_sync_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  vga_sync_gen_if.master vga
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_DISPLAY);
  localparam logic [9:0] V_ACT    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  // A one-bit divider is kept for CLK_DIV = 1; it then sits at 0, which is
  // also the terminal count, so the pixel enable is permanently high.
  localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic [9:0]       r_pix_x;
  logic [9:0]       r_pix_y;
  logic             r_hsync;
  logic             r_vsync;

  logic             w_div_last;
  logic             w_p_tick;
  logic             w_x_wrap;
  logic             w_y_wrap;
  logic [9:0]       w_x_next;
  logic [9:0]       w_y_next;
  logic             w_hsync_next;
  logic             w_vsync_next;

  always_comb begin
    w_div_last = (r_div == DIV_LAST);
    w_p_tick   = w_div_last && !reset;
    w_x_wrap   = (r_pix_x == H_LAST);
    w_y_wrap   = (r_pix_y == V_LAST);
    w_x_next   = r_pix_x;
    w_y_next   = r_pix_y;
    if (w_p_tick) begin
      w_x_next = w_x_wrap ? '0 : r_pix_x + 10'd1;
      if (w_x_wrap) begin
        w_y_next = w_y_wrap ? '0 : r_pix_y + 10'd1;
      end
    end
    // Syncs decode the next-count values so the registered outputs line up
    // with pix_x/pix_y in the same cycle.
    w_hsync_next = ((w_x_next >= HS_START) && (w_x_next <= HS_END)) ? SYNC_POL : ~SYNC_POL;
    w_vsync_next = ((w_y_next >= VS_START) && (w_y_next <= VS_END)) ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div   <= '0;
      r_pix_x <= '0;
      r_pix_y <= '0;
      r_hsync <= ~SYNC_POL;
      r_vsync <= ~SYNC_POL;
    end else begin
      r_div   <= w_div_last ? '0 : r_div + DIV_W'(1);
      r_pix_x <= w_x_next;
      r_pix_y <= w_y_next;
      r_hsync <= w_hsync_next;
      r_vsync <= w_vsync_next;
    end
  end

  assign vga.hsync     = r_hsync;
  assign vga.vsync     = r_vsync;
  assign vga.pix_x     = r_pix_x;
  assign vga.pix_y     = r_pix_y;
  assign vga.p_tick    = w_p_tick;
  assign vga.video_on  = (r_pix_x < H_ACT) && (r_pix_y < V_ACT) && !reset;
  // First pixel of vertical blanking: consumers may move objects here
  // without tearing an active line.
  assign vga.refr_tick = w_p_tick && (r_pix_x == '0) && (r_pix_y == V_ACT);

endmodule

// File: tb/tb_vga_sync_gen.sv
module tb_vga_sync_gen;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vga_sync_gen_if ifa ();
  vga_sync_gen_if ifb ();
  vga_sync_gen_if ifc ();

  // Full 640x480 timing.
  vga_sync_gen #(.CLK_DIV(2)) dut_a (.clk(clk), .reset(reset), .vga(ifa));

  // Scaled timing: H_TOTAL = 32 (sync 23..27), V_TOTAL = 17 (sync 12..13).
  vga_sync_gen #(
    .CLK_DIV(2), .H_DISPLAY(20), .H_FRONT(3), .H_SYNC(5), .H_BACK(4),
    .V_DISPLAY(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_POL(1'b0)
  ) dut_b (.clk(clk), .reset(reset), .vga(ifb));

  vga_sync_gen #(
    .CLK_DIV(1), .H_DISPLAY(20), .H_FRONT(3), .H_SYNC(5), .H_BACK(4),
    .V_DISPLAY(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_POL(1'b0)
  ) dut_c (.clk(clk), .reset(reset), .vga(ifc));

  // Leaves the bench 1 time unit after a falling-edge reset release.
  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({ifa.hsync, ifa.vsync, ifa.video_on, ifa.p_tick, ifa.refr_tick} !== 5'b11000) begin
      errors++;
      $display("FAIL rst_flags: got %b want 11000", {ifa.hsync, ifa.vsync, ifa.video_on, ifa.p_tick, ifa.refr_tick});
    end
    checks++;
    if ({ifa.pix_x, ifa.pix_y} !== 20'd0) begin
      errors++;
      $display("FAIL rst_pix: got x=%0d y=%0d want 0 0", ifa.pix_x, ifa.pix_y);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({ifa.p_tick, ifa.pix_x} !== 11'd0) begin
      errors++;
      $display("FAIL rst_hold: got p_tick=%b x=%0d want 0 0", ifa.p_tick, ifa.pix_x);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({ifa.video_on, ifa.p_tick, ifa.pix_x} !== {1'b1, 1'b0, 10'd0}) begin
      errors++;
      $display("FAIL rel_0: got von=%b p_tick=%b x=%0d want 1 0 0", ifa.video_on, ifa.p_tick, ifa.pix_x);
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      checks++;
      if ({ifa.p_tick, ifa.pix_x} !== {1'(k % 2), 10'(k / 2)}) begin
        errors++;
        $display("FAIL rel_seq k=%0d: got p_tick=%b x=%0d want %0d %0d", k, ifa.p_tick, ifa.pix_x, k % 2, k / 2);
      end
    end
  endtask

  task automatic test_line();
    int x, y, lows, first_low, last_low;
    logic eh, evo;
    lows = 0; first_low = -1; last_low = -1;
    release_reset();
    for (int n = 1; n <= 1600; n++) begin
      @(negedge clk);
      x = (n / 2) % 800;
      y = n / 1600;
      eh = !((x >= 656) && (x <= 751));
      evo = (x < 640);
      checks++;
      if ({ifa.pix_x, ifa.pix_y} !== {10'(x), 10'(y)}) begin
        errors++;
        $display("FAIL line_pix n=%0d: got %0d,%0d want %0d,%0d", n, ifa.pix_x, ifa.pix_y, x, y);
      end
      checks++;
      if ({ifa.hsync, ifa.vsync, ifa.video_on, ifa.p_tick, ifa.refr_tick} !== {eh, 1'b1, evo, 1'(n % 2), 1'b0}) begin
        errors++;
        $display("FAIL line_flags n=%0d: got %b want %b", n,
                 {ifa.hsync, ifa.vsync, ifa.video_on, ifa.p_tick, ifa.refr_tick}, {eh, 1'b1, evo, 1'(n % 2), 1'b0});
      end
      if (ifa.hsync === 1'b0) begin
        lows++;
        if (first_low < 0) first_low = n;
        last_low = n;
      end
    end
    checks++;
    if ((lows != 192) || (first_low != 1312) || (last_low != 1503)) begin
      errors++;
      $display("FAIL hsync_width: got clks=%0d first=%0d last=%0d want 192 1312 1503", lows, first_low, last_low);
    end
  endtask

  task automatic test_frame();
    int p, ex, ey, nref, first, second, overlap, act, vlow;
    logic eh, ev, evo, ept, er;
    nref = 0; first = 0; second = 0; overlap = 0; act = 0; vlow = 0;
    release_reset();
    for (int n = 1; n <= 2180; n++) begin
      @(negedge clk);
      p = n / 2;
      ex = p % 32;
      ey = (p / 32) % 17;
      ept = ((n % 2) == 1);
      eh = !((ex >= 23) && (ex <= 27));
      ev = !((ey >= 12) && (ey <= 13));
      evo = (ex < 20) && (ey < 10);
      er = ept && (ex == 0) && (ey == 10);
      checks++;
      if ({ifb.pix_x, ifb.pix_y} !== {10'(ex), 10'(ey)}) begin
        errors++;
        $display("FAIL frame_pix n=%0d: got %0d,%0d want %0d,%0d", n, ifb.pix_x, ifb.pix_y, ex, ey);
      end
      checks++;
      if ({ifb.hsync, ifb.vsync, ifb.video_on, ifb.p_tick, ifb.refr_tick} !== {eh, ev, evo, ept, er}) begin
        errors++;
        $display("FAIL frame_flags n=%0d: got %b want %b", n,
                 {ifb.hsync, ifb.vsync, ifb.video_on, ifb.p_tick, ifb.refr_tick}, {eh, ev, evo, ept, er});
      end
      if (ifb.refr_tick === 1'b1) begin
        if (nref == 0) first = n;
        if (nref == 1) second = n;
        nref++;
        if (ifb.video_on !== 1'b0) overlap++;
      end
      if ((n <= 1088) && (ifb.video_on === 1'b1) && (ifb.p_tick === 1'b1)) act++;
      if ((n <= 1088) && (ifb.vsync === 1'b0)) vlow++;
    end
    checks++;
    if ((nref != 2) || (first != 641) || (second - first != 1088)) begin
      errors++;
      $display("FAIL refr_tick: got count=%0d first=%0d gap=%0d want 2 641 1088", nref, first, second - first);
    end
    checks++;
    if (overlap != 0) begin
      errors++;
      $display("FAIL refr_overlap: got %0d want 0", overlap);
    end
    checks++;
    if (act != 200) begin
      errors++;
      $display("FAIL active_pixels: got %0d want 200", act);
    end
    checks++;
    if (vlow != 128) begin
      errors++;
      $display("FAIL vsync_width: got %0d clks want 128", vlow);
    end
  endtask

  task automatic test_clkdiv1();
    int ex, ey;
    release_reset();
    for (int n = 0; n <= 600; n++) begin
      if (n > 0) @(negedge clk);
      ex = n % 32;
      ey = (n / 32) % 17;
      checks++;
      if ({ifc.pix_x, ifc.pix_y, ifc.p_tick, ifc.refr_tick} !== {10'(ex), 10'(ey), 1'b1, 1'((ex == 0) && (ey == 10))}) begin
        errors++;
        $display("FAIL div1 n=%0d: got x=%0d y=%0d pt=%b rt=%b want %0d %0d 1 %b", n,
                 ifc.pix_x, ifc.pix_y, ifc.p_tick, ifc.refr_tick, ex, ey, (ex == 0) && (ey == 10));
      end
    end
  endtask

  task automatic test_midframe_reset();
    release_reset();
    repeat (819) @(negedge clk);
    checks++;
    if ({ifb.pix_x, ifb.pix_y, ifb.hsync, ifb.vsync, ifb.p_tick} !== {10'd25, 10'd12, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL mid_pre: got x=%0d y=%0d hs=%b vs=%b pt=%b want 25 12 0 0 1",
               ifb.pix_x, ifb.pix_y, ifb.hsync, ifb.vsync, ifb.p_tick);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({ifb.pix_x, ifb.pix_y} !== 20'd0) begin
      errors++;
      $display("FAIL mid_async_pix: got %0d,%0d want 0,0", ifb.pix_x, ifb.pix_y);
    end
    checks++;
    if ({ifb.hsync, ifb.vsync, ifb.video_on, ifb.p_tick, ifb.refr_tick} !== 5'b11000) begin
      errors++;
      $display("FAIL mid_async_flags: got %b want 11000", {ifb.hsync, ifb.vsync, ifb.video_on, ifb.p_tick, ifb.refr_tick});
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({ifb.pix_x, ifb.p_tick, ifb.video_on} !== 12'd0) begin
      errors++;
      $display("FAIL mid_hold: got x=%0d pt=%b von=%b want 0 0 0", ifb.pix_x, ifb.p_tick, ifb.video_on);
    end
    reset = 1'b0;
    #1;
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if ({ifb.p_tick, ifb.pix_x, ifb.pix_y, ifb.video_on} !== {1'(k % 2), 10'(k / 2), 10'd0, 1'b1}) begin
        errors++;
        $display("FAIL mid_restart k=%0d: got pt=%b x=%0d y=%0d von=%b want %0d %0d 0 1",
                 k, ifb.p_tick, ifb.pix_x, ifb.pix_y, ifb.video_on, k % 2, k / 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_clkdiv1();
    test_midframe_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
